// File: rtl/rotator_pkg.sv
// Shared types and constants for the sequential rotate engine.
//   rot_dir_t    : rotate direction (right = 0, left = 1)
//   rot_state_t  : control FSM states of seq_rotator
//   ROT_STEP_MAX : largest rotate distance applied in one clock
package rotator_pkg;

  typedef enum logic {
    ROT_RIGHT = 1'b0,
    ROT_LEFT  = 1'b1
  } rot_dir_t;

  typedef enum logic [1:0] {
    IDLE,
    ROTATE,
    DONE
  } rot_state_t;

  localparam int ROT_STEP_MAX = 3;

endpackage

// File: rtl/rot_step.sv
// Combinational 0..3-position rotator, the same small step used by the
// combinational rotators elsewhere in the library.
// Ports:
//   data    [N-1:0] : word to rotate
//   step    [1:0]   : rotate distance, 0..3
//   dir             : ROT_RIGHT or ROT_LEFT
//   rotated [N-1:0] : data rotated by step in direction dir
module rot_step
  import rotator_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] data,
  input  logic [1:0]   step,
  input  rot_dir_t     dir,
  output logic [N-1:0] rotated
);

  // Rotation as a shift of the word concatenated with itself: the bits that
  // fall off one end come back in from the other copy.
  logic [2*N-1:0] doubled;
  logic [2*N-1:0] shifted;

  always_comb begin
    doubled = {data, data};
    shifted = '0;
    rotated = '0;
    if (dir == ROT_LEFT) begin
      shifted = doubled << step;
      rotated = shifted[2*N-1:N];
    end else begin
      shifted = doubled >> step;
      rotated = shifted[N-1:0];
    end
  end

endmodule

// File: rtl/seq_rotator.sv
// Multi-cycle rotate engine. Rotates an N-bit word left or right by 0..N-1
// positions, at most ROT_STEP_MAX positions per clock, through a single
// rot_step instance on the data register feedback path.
//
// Ports:
//   clk, reset          : clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   : request handshake
//   in_data, in_shamt   : word to rotate and rotate amount
//   in_dir              : 0 = rotate right, 1 = rotate left
//   out_valid/out_ready : result handshake
//   out_data            : rotated word (meaningful only while out_valid)
//   busy                : high in every state except IDLE
//   dbg_state           : current FSM state, for checkers and debug
//   op_count [15:0]     : completed-result counter, present only when the
//                         macro SEQ_ROTATOR_OPCOUNT_EN is defined
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high. in_ready is high only in IDLE; in_* are ignored otherwise, so a
// producer may drop in_valid while in_ready is low without losing anything.
// In DONE, out_valid and out_data stay stable until out_ready is seen; the
// engine then returns to IDLE, so no request is taken on the output
// handshake edge.
module seq_rotator
  import rotator_pkg::*;
#(
  parameter int N = 8,
  localparam int SHW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_data,
  input  logic [SHW-1:0] in_shamt,
  input  logic           in_dir,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_data,
  output logic           busy,
`ifdef SEQ_ROTATOR_OPCOUNT_EN
  output logic [15:0]    op_count,
`endif
  output rot_state_t     dbg_state
);

  rot_state_t     state, state_next;
  logic [N-1:0]   data_q;
  logic [SHW-1:0] rem_q;
  rot_dir_t       dir_q;

  logic [1:0]     step;
  logic [SHW-1:0] rem_next;
  logic [N-1:0]   data_rot;

  // Largest step that does not overshoot the remaining distance.
  always_comb begin
    if (rem_q >= SHW'(ROT_STEP_MAX)) begin
      step = 2'(ROT_STEP_MAX);
    end else begin
      step = rem_q[1:0];
    end
    rem_next = rem_q - SHW'(step);
  end

  rot_step #(.N(N)) u_rot_step (
    .data    (data_q),
    .step    (step),
    .dir     (dir_q),
    .rotated (data_rot)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = (in_shamt == '0) ? DONE : ROTATE;
        end
      end
      ROTATE: begin
        if (rem_next == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers: load on accept, step while rotating, hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      rem_q  <= '0;
      dir_q  <= ROT_RIGHT;
    end else if (state == IDLE && in_valid) begin
      data_q <= in_data;
      rem_q  <= in_shamt;
      dir_q  <= rot_dir_t'(in_dir);
    end else if (state == ROTATE) begin
      data_q <= data_rot;
      rem_q  <= rem_next;
    end
  end

  // Output decode.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    out_data  = data_q;
    dbg_state = state;
  end

`ifdef SEQ_ROTATOR_OPCOUNT_EN
  // Counts output handshakes; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_count <= '0;
    end else if (out_valid && out_ready) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_rotator.sv
module tb_seq_rotator;
  import rotator_pkg::*;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_shamt;
  logic       in_dir;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  rot_state_t dbg_state;
`ifdef SEQ_ROTATOR_OPCOUNT_EN
  logic [15:0] op_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  seq_rotator #(.N(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
`ifdef SEQ_ROTATOR_OPCOUNT_EN
    .op_count  (op_count),
`endif
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Checking task
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks. All sampling and driving happens 1 time unit after a
  // rising edge, away from the active edge.
  task automatic send(input logic [7:0] d, input logic [2:0] sh, input logic dir);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = sh;
    in_dir   = dir;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Scramble ignored inputs while the engine is busy.
    in_data  = 8'($urandom_range(0, 255));
    in_shamt = 3'($urandom_range(0, 7));
    in_dir   = 1'($urandom_range(0, 1));
  endtask

  // Counts rising edges from (and including) the accept edge until
  // out_valid is seen; also counts samples where busy / in_ready were high.
  task automatic wait_done(output int lat, output int busy_cnt, output int rdy_cnt);
    lat      = 1;
    busy_cnt = busy ? 1 : 0;
    rdy_cnt  = in_ready ? 1 : 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busy_cnt++;
      if (in_ready) rdy_cnt++;
    end
  endtask

  task automatic run_op(input logic [7:0] d, input logic [2:0] sh, input logic dir,
                        input logic [7:0] exp_d, input int exp_lat, input string tag);
    int lat, busy_cnt, rdy_cnt;
    logic [7:0] exp_v;
    exp_q.push_back(exp_d);
    send(d, sh, dir);
    wait_done(lat, busy_cnt, rdy_cnt);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    exp_v = exp_q.pop_front();
    check({tag, "_out_data"}, 32'(out_data), 32'(exp_v));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    check({tag, "_in_ready_low"}, 32'(rdy_cnt), 32'd0);
    if (out_ready) begin
      @(posedge clk);
      #1;
      check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_back_idle"}, 32'(in_ready), 32'd1);
    end
  endtask

  // Stimulus
  initial begin
    logic [7:0] held;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_shamt  = 3'd0;
    in_dir    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors, expected values worked out by hand.
    run_op(8'h96, 3'd5, 1'b0, 8'hB4, 3, "ror5_96");
    run_op(8'h01, 3'd7, 1'b1, 8'h80, 4, "rol7_01");
    run_op(8'h01, 3'd1, 1'b0, 8'h80, 2, "ror1_01");
    run_op(8'hA5, 3'd0, 1'b1, 8'hA5, 1, "zero_A5");
    run_op(8'h96, 3'd3, 1'b1, 8'hB4, 2, "rol3_96");
    run_op(8'h96, 3'd7, 1'b0, 8'h2D, 4, "ror7_96");
    run_op(8'h96, 3'd1, 1'b1, 8'h2D, 2, "rol1_96");
    run_op(8'h3C, 3'd6, 1'b1, 8'h0F, 3, "rol6_3C");

    // Backpressure: hold the result, ignore a new request meanwhile.
    out_ready = 1'b0;
    run_op(8'h3C, 3'd2, 1'b1, 8'hF0, 2, "bp_rol2_3C");
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      in_data  = 8'h11;
      in_shamt = 3'd4;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_valid_hold", 32'(out_valid), 32'd1);
      check("bp_data_hold", 32'(out_data), 32'(held));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_state", 32'(dbg_state), 32'(IDLE));
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_ghost_op", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a rotation.
    send(8'h5A, 3'd7, 1'b1);
    @(posedge clk);
    #1;
    check("mid_rotating", 32'(dbg_state), 32'(ROTATE));
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_no_result", 32'(out_valid), 32'd0);
    run_op(8'h81, 3'd4, 1'b0, 8'h18, 3, "post_rst_ror4_81");

`ifdef SEQ_ROTATOR_OPCOUNT_EN
    run_op(8'hC3, 3'd2, 1'b0, 8'hF0, 2, "cnt_ror2_C3");
    run_op(8'h0F, 3'd4, 1'b1, 8'hF0, 3, "cnt_rol4_0F");
    check("op_count_3", 32'(op_count), 32'd3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("op_count_reset", 32'(op_count), 32'd0);
    #2;
    reset = 1'b0;
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
